// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
// Holds the FSM state encoding, master ids and width/lock defaults.
package dm_arb_pkg;

  localparam int unsigned AwDefault      = 6;
  localparam int unsigned DwDefault      = 32;
  localparam int unsigned LockMaxDefault = 16;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view; requesters and memory take the master view.
interface dm_arbiter_if #(
  parameter int unsigned AW = dm_arb_pkg::AwDefault,
  parameter int unsigned DW = dm_arb_pkg::DwDefault
);

  logic          m0_req,    m1_req;
  logic          m0_we,     m1_we;
  logic          m0_lock,   m1_lock;
  logic [AW-1:0] m0_addr,   m1_addr;
  logic [DW-1:0] m0_wdata,  m1_wdata;
  logic          m0_gnt,    m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata,  m1_rdata;

  logic          Mem_Write;
  logic [AW-1:0] DM_Addr;
  logic [DW-1:0] M_W_Data;
  logic [DW-1:0] M_R_Data;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
    input  m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output Mem_Write, DM_Addr, M_W_Data,
    input  M_R_Data
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
    output m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  Mem_Write, DM_Addr, M_W_Data,
    output M_R_Data
  );

endinterface

// File: rtl/dm_rr_pick.sv
// Two-way round-robin picker: on a tie the master that was not granted last wins.
module dm_rr_pick import dm_arb_pkg::*; (
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_last_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = req0_i & (~req1_i | (rr_last_i == M1));
  assign gnt1_o = req1_i & (~req0_i | (rr_last_i == M0));

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port data memory: round-robin on ties,
// bounded lock for atomic sequences, registered read data back to the requester.
module dm_arbiter import dm_arb_pkg::*; #(
  parameter int unsigned AW       = AwDefault,
  parameter int unsigned DW       = DwDefault,
  parameter int unsigned LOCK_MAX = LockMaxDefault
) (
  input logic         clk_dm,
  input logic         rst_n,
  dm_arbiter_if.slave bus
);

  localparam int unsigned    CntW    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

  dm_state_e       state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]      rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;

  logic [1:0]    req, we, lock;
  logic [1:0]    pick_gnt, gnt_raw, gnt;
  logic          pick_id, owner;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  assign req  = {bus.m1_req,  bus.m0_req};
  assign we   = {bus.m1_we,   bus.m0_we};
  assign lock = {bus.m1_lock, bus.m0_lock};

  dm_rr_pick u_pick (
    .req0_i    (req[M0]),
    .req1_i    (req[M1]),
    .rr_last_i (rr_last_q),
    .gnt0_o    (pick_gnt[M0]),
    .gnt1_o    (pick_gnt[M1])
  );

  assign pick_id = pick_gnt[M1] ? M1 : M0;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    gnt_raw    = '0;
    owner      = (state_q == StLock1) ? M1 : M0;
    unique case (state_q)
      StArb: begin
        gnt_raw = pick_gnt;
        if (|pick_gnt) begin
          rr_last_d = pick_id;
          if (lock[pick_id]) begin
            state_d    = (pick_id == M1) ? StLock1 : StLock0;
            lock_cnt_d = '0;
          end
        end
      end
      StLock0, StLock1: begin
        gnt_raw[owner] = req[owner];
        lock_cnt_d     = lock_cnt_q + 1'b1;
        // Owner keeps rr_last, so a forced release hands the next tie to the other master.
        rr_last_d      = owner;
        if (!req[owner] || !lock[owner] || (lock_cnt_q == CntLast)) begin
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  assign gnt = gnt_raw & {2{rst_n}};

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[M0]) begin
      mem_we    = we[M0];
      mem_addr  = bus.m0_addr;
      mem_wdata = bus.m0_wdata;
    end else if (gnt[M1]) begin
      mem_we    = we[M1];
      mem_addr  = bus.m1_addr;
      mem_wdata = bus.m1_wdata;
    end
  end

  always_comb begin
    rvalid_d = gnt & ~we;
    rdata0_d = rvalid_d[M0] ? bus.M_R_Data : rdata0_q;
    rdata1_d = rvalid_d[M1] ? bus.M_R_Data : rdata1_q;
  end

  always_ff @(posedge clk_dm) begin
    if (!rst_n) begin
      state_q    <= StArb;
      rr_last_q  <= M1;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.m0_gnt    = gnt[M0];
  assign bus.m1_gnt    = gnt[M1];
  assign bus.m0_rvalid = rvalid_q[M0];
  assign bus.m1_rvalid = rvalid_q[M1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.Mem_Write = mem_we;
  assign bus.DM_Addr   = mem_addr;
  assign bus.M_W_Data  = mem_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 64x32 memory model preloaded to 0x1000+addr.
module tb_dm_arbiter;

  logic clk_dm = 1'b0;
  logic rst_n;
  logic mem_load;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [31:0] mem [64];

  always #5 clk_dm = ~clk_dm;

  dm_arbiter_if #(.AW(6), .DW(32)) bus ();

  dm_arbiter #(.AW(6), .DW(32), .LOCK_MAX(16)) dut (
    .clk_dm (clk_dm),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  assign bus.M_R_Data = mem[bus.DM_Addr];

  always @(posedge clk_dm) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + 32'(i);
    end else if (bus.Mem_Write) begin
      mem[bus.DM_Addr] <= bus.M_W_Data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [5:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [5:0] a1, input logic [31:0] d1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk_dm);
    #1;
  endtask

  initial begin
    int  i0, i1;
    logic exp0, prev_m1;

    // Reset with m0 attempting a write: must be blocked.
    rst_n = 1'b0; mem_load = 1'b1; idle();
    tick();
    mem_load = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 6'd5, 32'hBAD, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    #1;
    check_eq("rst_m0_gnt",    32'(bus.m0_gnt),    32'd0);
    check_eq("rst_mem_write", 32'(bus.Mem_Write), 32'd0);
    check_eq("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    check_eq("rst_m0_rdata",  bus.m0_rdata,       32'd0);
    check_eq("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    tick();

    // Single m0 read of addr 5.
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 6'd5, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    #1;
    check_eq("rd5_m0_gnt",    32'(bus.m0_gnt),    32'd1);
    check_eq("rd5_m1_gnt",    32'(bus.m1_gnt),    32'd0);
    check_eq("rd5_dm_addr",   32'(bus.DM_Addr),   32'd5);
    check_eq("rd5_mem_write", 32'(bus.Mem_Write), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 6'd5, 32'd0);
    #1;
    check_eq("rd5_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    check_eq("rd5_m0_rdata",  bus.m0_rdata,       32'h1005);
    check_eq("rd5_m1_gnt",    32'(bus.m1_gnt),    32'd1);
    tick();
    idle();
    #1;
    check_eq("rd5_m0_rvalid_drop", 32'(bus.m0_rvalid), 32'd0);
    check_eq("rd5_m0_rdata_hold",  bus.m0_rdata,       32'h1005);
    check_eq("rd5_m1_rdata",       bus.m1_rdata,       32'h1005);
    check_eq("idle_dm_addr",       32'(bus.DM_Addr),   32'd0);
    tick();

    // Continuous contention: strict alternation starting with m0.
    i0 = 0; i1 = 0; prev_m1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b0, 6'(1 + i0), 32'(32'hA0 + 1 + i0),
            1'b1, 1'b0, 1'b0, 6'(10 + i1), 32'd0);
      #1;
      exp0 = ((k % 2) == 0);
      check_eq($sformatf("alt%0d_m0_gnt", k),  32'(bus.m0_gnt),    32'(exp0));
      check_eq($sformatf("alt%0d_m1_gnt", k),  32'(bus.m1_gnt),    32'(!exp0));
      check_eq($sformatf("alt%0d_dm_addr", k), 32'(bus.DM_Addr),   exp0 ? 32'(1 + i0) : 32'(10 + i1));
      check_eq($sformatf("alt%0d_mem_we", k),  32'(bus.Mem_Write), 32'(exp0));
      check_eq($sformatf("alt%0d_m1_rvld", k), 32'(bus.m1_rvalid), 32'(prev_m1));
      if (prev_m1) check_eq($sformatf("alt%0d_m1_rdata", k), bus.m1_rdata, 32'h1000 + 32'(9 + i1));
      if (exp0) i0++; else i1++;
      prev_m1 = !exp0;
      tick();
    end
    idle();
    #1;
    check_eq("alt_end_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    check_eq("alt_end_m1_rdata",  bus.m1_rdata,       32'h100C);
    check_eq("alt_mem2_written",  mem[2],             32'hA2);
    tick();

    // Write-then-read forwarding through memory.
    drive(1'b1, 1'b1, 1'b0, 6'd7, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    #1;
    check_eq("wr7_mem_write", 32'(bus.Mem_Write), 32'd1);
    check_eq("wr7_dm_addr",   32'(bus.DM_Addr),   32'd7);
    check_eq("wr7_wdata",     bus.M_W_Data,       32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 6'd7, 32'd0);
    #1;
    check_eq("rd7_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    idle();
    #1;
    check_eq("rd7_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    check_eq("rd7_m1_rdata",  bus.m1_rdata,       32'hDEADBEEF);
    tick();

    // Lock for three accesses, release on the fourth; m1 gets the next cycle.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, (k < 3), 6'(20 + k), 32'd0, 1'b1, 1'b0, 1'b0, 6'd30, 32'd0);
      #1;
      check_eq($sformatf("lk%0d_m0_gnt", k), 32'(bus.m0_gnt), 32'(k < 4));
      check_eq($sformatf("lk%0d_m1_gnt", k), 32'(bus.m1_gnt), 32'(k == 4));
      tick();
    end
    idle();
    tick();

    // Lock held forever: forced release after 16 locked cycles.
    for (int k = 0; k < 19; k++) begin
      drive(1'b1, 1'b0, (k < 18), 6'd3, 32'd0, 1'b1, 1'b0, 1'b0, 6'd30, 32'd0);
      #1;
      check_eq($sformatf("fr%0d_m0_gnt", k), 32'(bus.m0_gnt), 32'((k <= 16) || (k == 18)));
      check_eq($sformatf("fr%0d_m1_gnt", k), 32'(bus.m1_gnt), 32'(k == 17));
      tick();
    end
    idle();
    tick();

    // Reset while m1 holds the lock.
    drive(1'b1, 1'b0, 1'b0, 6'd4, 32'd0, 1'b1, 1'b0, 1'b1, 6'd6, 32'd0);
    #1;
    check_eq("rl_enter_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    #1;
    check_eq("rl_hold_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    check_eq("rl_hold_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 6'd4, 32'd0, 1'b1, 1'b1, 1'b1, 6'd6, 32'h5555);
    #1;
    check_eq("rl_rst_m0_gnt",    32'(bus.m0_gnt),    32'd0);
    check_eq("rl_rst_m1_gnt",    32'(bus.m1_gnt),    32'd0);
    check_eq("rl_rst_mem_write", 32'(bus.Mem_Write), 32'd0);
    tick();
    #1;
    check_eq("rl_rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    check_eq("rl_rst_m1_rdata",  bus.m1_rdata,       32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 6'd4, 32'd0, 1'b1, 1'b0, 1'b1, 6'd6, 32'd0);
    #1;
    check_eq("rl_post_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    check_eq("rl_post_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    check_eq("rl_mem6_intact", mem[6],          32'h1006);
    tick();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
